// File: rtl/clock_time_counter_if.sv
// Control and display bundle of the timekeeping core.
// The master drives enable and the set pulses; the slave returns time and blink.
interface clock_time_counter_if;
    logic        enable;
    logic        inc_min;
    logic        inc_hour;
    logic [15:0] value;
    logic        sec_tick;
    logic        colon;

    modport master (
        output enable, inc_min, inc_hour,
        input  value, sec_tick, colon
    );

    modport slave (
        input  enable, inc_min, inc_hour,
        output value, sec_tick, colon
    );
endinterface

// File: rtl/clock_time_counter.sv
// 24-hour BCD timekeeper: divides the system clock to 1 Hz, keeps HH:MM:SS,
// and exposes HH:MM, a one-cycle second strobe and a colon blink.
module clock_time_counter #(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic                 clock,
    input  logic                 reset,
    clock_time_counter_if.slave  bus
);
    localparam int unsigned PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    sec_u_q, sec_u_d;
    logic [2:0]    sec_t_q, sec_t_d;
    logic [3:0]    min_u_q, min_u_d;
    logic [2:0]    min_t_q, min_t_d;
    logic [3:0]    hr_u_q, hr_u_d;
    logic [1:0]    hr_t_q, hr_t_d;
    logic          sec_tick_q, sec_tick_d;
    logic          colon_q, colon_d;

    logic tick, do_tick, sec_wrap, min_wrap, min_adv, hr_adv;

    always_comb begin
        tick     = bus.enable && (presc_q == PW'(CLK_HZ - 1));
        // A set pulse swallows a coinciding second tick entirely.
        do_tick  = tick && !bus.inc_min && !bus.inc_hour;
        sec_wrap = (sec_t_q == 3'd5) && (sec_u_q == 4'd9);
        min_wrap = (min_t_q == 3'd5) && (min_u_q == 4'd9);
        min_adv  = bus.inc_min || (do_tick && sec_wrap);
        hr_adv   = bus.inc_hour || (do_tick && sec_wrap && min_wrap);

        presc_d = presc_q;
        sec_u_d = sec_u_q;
        sec_t_d = sec_t_q;
        min_u_d = min_u_q;
        min_t_d = min_t_q;
        hr_u_d  = hr_u_q;
        hr_t_d  = hr_t_q;

        if (bus.inc_min) begin
            presc_d = '0;
        end else if (bus.enable) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end

        if (bus.inc_min) begin
            sec_u_d = 4'd0;
            sec_t_d = 3'd0;
        end else if (do_tick) begin
            if (sec_u_q == 4'd9) begin
                sec_u_d = 4'd0;
                sec_t_d = sec_wrap ? 3'd0 : sec_t_q + 3'd1;
            end else begin
                sec_u_d = sec_u_q + 4'd1;
            end
        end

        if (min_adv) begin
            if (min_u_q == 4'd9) begin
                min_u_d = 4'd0;
                min_t_d = min_wrap ? 3'd0 : min_t_q + 3'd1;
            end else begin
                min_u_d = min_u_q + 4'd1;
            end
        end

        if (hr_adv) begin
            if ((hr_t_q == 2'd2) && (hr_u_q == 4'd3)) begin
                hr_u_d = 4'd0;
                hr_t_d = 2'd0;
            end else if (hr_u_q == 4'd9) begin
                hr_u_d = 4'd0;
                hr_t_d = hr_t_q + 2'd1;
            end else begin
                hr_u_d = hr_u_q + 4'd1;
            end
        end

        sec_tick_d = do_tick;
        colon_d    = (presc_d < PW'(CLK_HZ / 2));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_q    <= '0;
            sec_u_q    <= '0;
            sec_t_q    <= '0;
            min_u_q    <= '0;
            min_t_q    <= '0;
            hr_u_q     <= '0;
            hr_t_q     <= '0;
            sec_tick_q <= 1'b0;
            colon_q    <= 1'b1;
        end else begin
            presc_q    <= presc_d;
            sec_u_q    <= sec_u_d;
            sec_t_q    <= sec_t_d;
            min_u_q    <= min_u_d;
            min_t_q    <= min_t_d;
            hr_u_q     <= hr_u_d;
            hr_t_q     <= hr_t_d;
            sec_tick_q <= sec_tick_d;
            colon_q    <= colon_d;
        end
    end

    assign bus.value    = {2'b00, hr_t_q, hr_u_q, 1'b0, min_t_q, min_u_q};
    assign bus.sec_tick = sec_tick_q;
    assign bus.colon    = colon_q;
endmodule

// File: tb/tb_clock_time_counter.sv
// Bench for clock_time_counter: directed scenarios plus random pulses, every cycle
// compared against a time-of-day model kept in plain integer seconds.
module tb_clock_time_counter;
    localparam int unsigned HZ = 4;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    int   m_presc, m_hour, m_min, m_sec, m_ticks;
    logic m_tick;

    clock_time_counter_if bus ();

    clock_time_counter #(.CLK_HZ(HZ)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [15:0] bcd_hhmm(int h, int m);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_presc = 0; m_hour = 0; m_min = 0; m_sec = 0; m_tick = 1'b0;
    endtask

    task automatic model_step(input logic en, input logic im, input logic ih);
        int s;
        m_tick = en && (m_presc == HZ - 1) && !im && !ih;
        if (im) begin
            m_min   = (m_min + 1) % 60;
            m_sec   = 0;
            m_presc = 0;
        end else if (en) begin
            m_presc = (m_presc + 1) % HZ;
        end
        if (ih) m_hour = (m_hour + 1) % 24;
        if (m_tick) begin
            s      = ((m_hour * 60 + m_min) * 60 + m_sec + 1) % 86400;
            m_hour = s / 3600;
            m_min  = (s / 60) % 60;
            m_sec  = s % 60;
            m_ticks++;
        end
    endtask

    // One clock: drive, clock, advance model, compare all outputs just after the edge.
    task automatic step(input logic en, input logic im, input logic ih, input string tag);
        bus.enable   = en;
        bus.inc_min  = im;
        bus.inc_hour = ih;
        @(posedge clock);
        model_step(en, im, ih);
        #1;
        chk({tag, ".value"}, bus.value, bcd_hhmm(m_hour, m_min));
        chk({tag, ".tick"}, 16'(bus.sec_tick), 16'(m_tick));
        chk({tag, ".colon"}, 16'(bus.colon), 16'(m_presc < HZ / 2));
    endtask

    // Asynchronous reset asserted between edges; outputs must clear before the next edge.
    task automatic do_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        model_clear();
        chk({tag, ".rst_value"}, bus.value, 16'h0000);
        chk({tag, ".rst_tick"}, 16'(bus.sec_tick), 16'h0000);
        chk({tag, ".rst_colon"}, 16'(bus.colon), 16'h0001);
        #2 reset = 1'b0;
    endtask

    initial begin
        int n;
        total = 0; bad = 0; m_ticks = 0;
        reset = 1'b0;
        bus.enable = 1'b0; bus.inc_min = 1'b0; bus.inc_hour = 1'b0;
        model_clear();
        #1;
        do_reset("t0");

        // 1: free run, four strobes in sixteen cycles
        m_ticks = 0;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 1'b0, "t1");
            if (bus.sec_tick === 1'b1) n++;
        end
        chk("t1.count", 16'(n), 16'(4));
        chk("t1.value", bus.value, 16'h0000);

        // 4: frozen while disabled, set pulse still lands
        step(1'b1, 1'b0, 1'b0, "t4");
        step(1'b1, 1'b0, 1'b0, "t4");
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, (i == 10), 1'b0, "t4");
            if (bus.sec_tick === 1'b1) n++;
        end
        chk("t4.notick", 16'(n), 16'(0));
        chk("t4.value", bus.value, 16'h0001);

        // 2: roll-over from 23:59:00
        do_reset("t2");
        for (int i = 0; i < 23; i++) step(1'b0, 1'b0, 1'b1, "t2set");
        for (int i = 0; i < 59; i++) step(1'b0, 1'b1, 1'b0, "t2set");
        chk("t2.start", bus.value, 16'h2359);
        m_ticks = 0;
        for (int i = 0; i < 60 * HZ; i++) begin
            step(1'b1, 1'b0, 1'b0, "t2");
            if (m_tick && m_ticks == 59) chk("t2.before", bus.value, 16'h2359);
            if (m_tick && m_ticks == 60) chk("t2.wrap", bus.value, 16'h0000);
        end

        // 3: set pulses never carry
        do_reset("t3");
        for (int i = 0; i < 59; i++) step(1'b0, 1'b1, 1'b0, "t3set");
        chk("t3.at0059", bus.value, 16'h0059);
        step(1'b0, 1'b1, 1'b0, "t3");
        chk("t3.minwrap", bus.value, 16'h0000);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, "t3set");
        for (int i = 0; i < 23; i++) step(1'b0, 1'b0, 1'b1, "t3set");
        chk("t3.at2307", bus.value, 16'h2307);
        step(1'b0, 1'b0, 1'b1, "t3");
        chk("t3.hrwrap", bus.value, 16'h0007);
        step(1'b0, 1'b1, 1'b1, "t3both");
        chk("t3.both", bus.value, 16'h0108);

        // 5: set pulse coincides with the tick at 12:34:59
        do_reset("t5");
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b1, "t5set");
        for (int i = 0; i < 34; i++) step(1'b0, 1'b1, 1'b0, "t5set");
        for (int i = 0; i < 59 * HZ + HZ - 1; i++) step(1'b1, 1'b0, 1'b0, "t5run");
        step(1'b1, 1'b1, 1'b0, "t5");
        chk("t5.value", bus.value, 16'h1235);
        chk("t5.notick", 16'(bus.sec_tick), 16'h0000);
        for (int i = 1; i <= HZ; i++) begin
            step(1'b1, 1'b0, 1'b0, "t5after");
            chk("t5.nexttick", 16'(bus.sec_tick), 16'(i == HZ));
        end

        // 6: asynchronous reset mid-prescaler at 09:17
        do_reset("t6pre");
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b1, "t6set");
        for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 1'b0, "t6set");
        step(1'b1, 1'b0, 1'b0, "t6");
        step(1'b1, 1'b0, 1'b0, "t6");
        chk("t6.start", bus.value, 16'h0917);
        do_reset("t6");
        for (int i = 0; i < 3 * HZ; i++) step(1'b1, 1'b0, 1'b0, "t6restart");

        // random enables and set pulses
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 8) != 0, ($urandom % 16) == 0, ($urandom % 20) == 0, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
